track_transport_ctrl: RTL and testbench

- Transport controller directly upstream of track_store_load. Turns user record/play/stop commands and the audio sample-rate tick into the store_req/load_req levels and the single-cycle wr/rd strobes that the store/load stage consumes.
- On record: pushes one mic sample per tick, then on stop pads the take with zero words to a whole 512-byte sector and holds store_req through a drain window.
- On play: pulls one word per tick, captures the returned word and presents it to the audio output path.
- Tracks the recorded take length in words.

---
 rtl/recorder_pkg.sv | 22 ++
 rtl/strobe_gen.sv | 31 +++
 rtl/track_transport_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_track_transport_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// Shared recorder definitions: transport state encoding and sector geometry.
// Used by the transport controller and by track_store_load users.
package recorder_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRec   = 3'd1,
        StPad   = 3'd2,
        StDrain = 3'd3,
        StPlay  = 3'd4
    } rec_state_e;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned WORD_BITS    = 16;
    localparam int unsigned SECTOR_WORDS = SECTOR_BYTES * 8 / WORD_BITS;

    // States in which the store path must be held requested.
    function automatic logic is_store_state(input rec_state_e st);
        return (st == StRec) || (st == StPad) || (st == StDrain);
    endfunction

endpackage

// File: rtl/strobe_gen.sv
// Turns single-cycle requests into single-cycle pulses that are always separated by at
// least one low cycle, so an edge-detecting consumer never sees two strobes merge.
module strobe_gen (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    output logic pulse_o
);

    logic pulse_q, pulse_d;
    logic pend_q, pend_d;

    // A request landing on a high pulse is held one deep and issued after the gap.
    always_comb begin
        pulse_d = (req_i || pend_q) && !pulse_q;
        pend_d  = (req_i || pend_q) && pulse_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/track_transport_ctrl.sv
// Transport controller feeding track_store_load: converts record/play/stop commands and
// the sample-rate tick into store/load request levels and single-cycle wr/rd strobes.
module track_transport_ctrl #(
    parameter int unsigned WORD_WIDTH   = 16,
    parameter int unsigned SECTOR_WORDS = recorder_pkg::SECTOR_WORDS,
    parameter int unsigned LEN_W        = 24,
    parameter int unsigned PAD_GAP      = 4,
    parameter int unsigned DRAIN_CYCLES = 65536,
    parameter int unsigned RD_LAT       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_start,
    input  logic                  play_start,
    input  logic                  stop,
    input  logic                  sample_tick,
    input  logic [WORD_WIDTH-1:0] mic_sample,
    output logic [WORD_WIDTH-1:0] play_sample,
    output logic                  play_valid,
    output logic                  busy,
    output logic [2:0]            state_o,
    output logic [LEN_W-1:0]      rec_len,
    output logic                  store_req,
    output logic                  load_req,
    output logic                  wr,
    output logic [WORD_WIDTH-1:0] din,
    output logic                  rd,
    input  logic [WORD_WIDTH-1:0] dout
);

    import recorder_pkg::*;

    localparam int unsigned SW_BITS = $clog2(SECTOR_WORDS);
    localparam int unsigned PAD_W   = $clog2(PAD_GAP) + 1;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
    localparam int unsigned RD_W    = $clog2(RD_LAT + 1);

    // 2^LEN_W - SECTOR_WORDS: last sector-aligned count that still leaves room to pad.
    localparam logic [LEN_W-1:0] WC_LIMIT = ~LEN_W'(SECTOR_WORDS - 1);

    rec_state_e            state_q, state_d;
    logic [LEN_W-1:0]      wc_q, wc_d;
    logic [LEN_W-1:0]      rec_len_q, rec_len_d;
    logic [PAD_W-1:0]      pad_cnt_q, pad_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [RD_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [WORD_WIDTH-1:0] din_q, din_d;
    logic [WORD_WIDTH-1:0] play_sample_q, play_sample_d;
    logic                  play_valid_q, play_valid_d;
    logic                  store_req_q, store_req_d;
    logic                  load_req_q, load_req_d;
    logic                  busy_q, busy_d;
    logic                  wr_req, rd_req;
    logic                  capture;
    logic                  aligned;
    logic                  rd_idle;

    // rd_cnt counts down the read latency independently of state so that a capture
    // already in flight still completes after PLAY is left.
    assign capture = (rd_cnt_q == RD_W'(1));
    assign rd_idle = (rd_cnt_q == '0);
    assign aligned = (wc_q[SW_BITS-1:0] == '0);

    always_comb begin
        state_d       = state_q;
        wc_d          = wc_q;
        rec_len_d     = rec_len_q;
        pad_cnt_d     = pad_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        din_d         = din_q;
        wr_req        = 1'b0;
        rd_req        = 1'b0;
        rd_cnt_d      = rd_idle ? '0 : rd_cnt_q - RD_W'(1);
        play_valid_d  = capture;
        play_sample_d = capture ? dout : play_sample_q;

        unique case (state_q)
            StIdle: begin
                if (rec_start) begin
                    state_d = StRec;
                    wc_d    = '0;
                end else if (play_start && (rec_len_q != '0)) begin
                    state_d = StPlay;
                    wc_d    = '0;
                end
            end
            StRec: begin
                // stop beats a coincident tick; that sample is dropped
                if (stop || (wc_q == WC_LIMIT)) begin
                    state_d   = StPad;
                    pad_cnt_d = PAD_W'(PAD_GAP - 1);
                end else if (sample_tick) begin
                    wr_req = 1'b1;
                    din_d  = mic_sample;
                    wc_d   = wc_q + LEN_W'(1);
                end
            end
            StPad: begin
                if (aligned) begin
                    rec_len_d   = wc_q;
                    state_d     = StDrain;
                    drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
                end else if (pad_cnt_q == '0) begin
                    wr_req    = 1'b1;
                    din_d     = '0;
                    wc_d      = wc_q + LEN_W'(1);
                    pad_cnt_d = PAD_W'(PAD_GAP - 1);
                end else begin
                    pad_cnt_d = pad_cnt_q - PAD_W'(1);
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            StPlay: begin
                if (stop || (capture && (wc_q == rec_len_q))) begin
                    state_d = StIdle;
                end else if (sample_tick && rd_idle && (wc_q != rec_len_q)) begin
                    rd_req   = 1'b1;
                    wc_d     = wc_q + LEN_W'(1);
                    rd_cnt_d = RD_W'(RD_LAT);
                end
            end
            default: state_d = StIdle;
        endcase

        store_req_d = is_store_state(state_d);
        load_req_d  = (state_d == StPlay);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wc_q          <= '0;
            rec_len_q     <= '0;
            pad_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            rd_cnt_q      <= '0;
            din_q         <= '0;
            play_sample_q <= '0;
            play_valid_q  <= 1'b0;
            store_req_q   <= 1'b0;
            load_req_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wc_q          <= wc_d;
            rec_len_q     <= rec_len_d;
            pad_cnt_q     <= pad_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            din_q         <= din_d;
            play_sample_q <= play_sample_d;
            play_valid_q  <= play_valid_d;
            store_req_q   <= store_req_d;
            load_req_q    <= load_req_d;
            busy_q        <= busy_d;
        end
    end

    strobe_gen u_wr_strobe (
        .clk     (clk),
        .rst     (rst),
        .req_i   (wr_req),
        .pulse_o (wr)
    );

    strobe_gen u_rd_strobe (
        .clk     (clk),
        .rst     (rst),
        .req_i   (rd_req),
        .pulse_o (rd)
    );

    assign state_o     = state_q;
    assign rec_len     = rec_len_q;
    assign din         = din_q;
    assign play_sample = play_sample_q;
    assign play_valid  = play_valid_q;
    assign store_req   = store_req_q;
    assign load_req    = load_req_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_track_transport_ctrl.sv
// Scoreboard bench for track_transport_ctrl: stimulus queues expected wr/play words,
// a negedge monitor pops and compares whenever the DUT strobes.
module tb_track_transport_ctrl;

    localparam int DRAIN   = 1024;
    localparam int PAD_GAP = 4;
    localparam int RD_LAT  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec_start = 1'b0;
    logic        play_start = 1'b0;
    logic        stop = 1'b0;
    logic        sample_tick = 1'b0;
    logic [15:0] mic_sample = '0;
    logic [15:0] play_sample;
    logic        play_valid;
    logic        busy;
    logic [2:0]  state_o;
    logic [23:0] rec_len;
    logic        store_req;
    logic        load_req;
    logic        wr;
    logic [15:0] din;
    logic        rd;
    logic [15:0] dout = '0;

    track_transport_ctrl #(
        .WORD_WIDTH   (16),
        .SECTOR_WORDS (256),
        .LEN_W        (24),
        .PAD_GAP      (PAD_GAP),
        .DRAIN_CYCLES (DRAIN),
        .RD_LAT       (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rec_start   (rec_start),
        .play_start  (play_start),
        .stop        (stop),
        .sample_tick (sample_tick),
        .mic_sample  (mic_sample),
        .play_sample (play_sample),
        .play_valid  (play_valid),
        .busy        (busy),
        .state_o     (state_o),
        .rec_len     (rec_len),
        .store_req   (store_req),
        .load_req    (load_req),
        .wr          (wr),
        .din         (din),
        .rd          (rd),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pad;
        logic [15:0] d;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [15:0] pv_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int rd_cyc = 0;
    int wr_total = 0;
    int rd_count = 0;
    int pv_count = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic prev_pad = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, strobe-gap checks and the load-path dout model.
    always @(negedge clk) begin
        wr_exp_t e;
        logic [15:0] pe;
        if (wr) begin
            chk("wr_gap", 32'(prev_wr), 0);
            chk("wr_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                chk("wr_din", 32'(din), 32'(e.d));
                if (e.pad && prev_pad) chk("pad_gap", cyc - last_wr_cyc, PAD_GAP);
                prev_pad = e.pad;
            end
            last_wr_cyc = cyc;
            wr_total++;
        end
        if (rd) begin
            chk("rd_gap", 32'(prev_rd), 0);
            rd_cyc = cyc;
            rd_count++;
            dout = 16'(rd_count);
        end
        if (play_valid) begin
            chk("pv_expected", 32'(pv_q.size() != 0), 1);
            if (pv_q.size() != 0) begin
                pe = pv_q.pop_front();
                chk("play_sample", 32'(play_sample), 32'(pe));
            end
            chk("pv_latency", cyc - rd_cyc, RD_LAT);
            pv_count++;
        end
        prev_wr = wr;
        prev_rd = rd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic r, input logic p, input logic s);
        rec_start = r;
        play_start = p;
        stop = s;
        step();
        rec_start = 1'b0;
        play_start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic tick(input logic [15:0] s, input int gap);
        mic_sample = s;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        mic_sample = '0;
        repeat (gap) step();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(state_o), 32'(s));
    endtask

    task automatic push_pads(input int n);
        for (int i = 0; i < n; i++) wr_q.push_back('{pad: 1'b1, d: 16'h0000});
    endtask

    initial begin
        int n;
        int snap;

        // Reset state
        repeat (3) step();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_outs", 32'({wr, rd, play_valid, busy, store_req, load_req}), 0);
        chk("rst_rec_len", 32'(rec_len), 0);
        chk("rst_din", 32'(din), 0);
        rst = 1'b0;
        step();

        // 1: ten samples, stop, pad to a full sector, drain
        cmd(1'b1, 1'b0, 1'b0);
        chk("t1_rec", 32'(state_o), 1);
        chk("t1_store_req", 32'(store_req), 1);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 1; i <= 10; i++) begin
            wr_q.push_back('{pad: 1'b0, d: 16'(i)});
            tick(16'(i), 2);
        end
        push_pads(246);
        cmd(1'b0, 1'b0, 1'b1);
        chk("t1_pad", 32'(state_o), 2);
        wait_state(3'd3, 2000, "t1_drain");
        chk("t1_rec_len", 32'(rec_len), 256);
        chk("t1_store_in_drain", 32'(store_req), 1);
        n = 0;
        while (store_req === 1'b1 && n < DRAIN + 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_drain_len", cyc - last_wr_cyc - 1, DRAIN);
        chk("t1_idle", 32'(state_o), 0);
        chk("t1_not_busy", 32'(busy), 0);
        chk("t1_all_wr", wr_q.size(), 0);

        // 2: exactly one sector, no padding
        step();
        cmd(1'b1, 1'b0, 1'b0);
        snap = wr_total;
        for (int i = 0; i < 256; i++) begin
            wr_q.push_back('{pad: 1'b0, d: 16'(16'h1000 + i)});
            tick(16'(16'h1000 + i), 1);
        end
        cmd(1'b0, 1'b0, 1'b1);
        chk("t2_pad", 32'(state_o), 2);
        step();
        chk("t2_drain_direct", 32'(state_o), 3);
        chk("t2_rec_len", 32'(rec_len), 256);
        chk("t2_wr_count", wr_total - snap, 256);
        wait_state(3'd0, DRAIN + 50, "t2_idle");
        chk("t2_all_wr", wr_q.size(), 0);

        // 3: full playback with dout = rd count
        step();
        rd_count = 0;
        pv_count = 0;
        cmd(1'b0, 1'b1, 1'b0);
        chk("t3_play", 32'(state_o), 4);
        chk("t3_load_req", 32'(load_req), 1);
        for (int k = 1; k <= 256; k++) begin
            pv_q.push_back(16'(k));
            tick(16'h0, 5);
        end
        wait_state(3'd0, 20, "t3_idle");
        chk("t3_load_drop", 32'(load_req), 0);
        chk("t3_rd_count", rd_count, 256);
        chk("t3_pv_count", pv_count, 256);
        chk("t3_all_pv", pv_q.size(), 0);

        // 4: rec+play together -> REC; stop with tick drops the sample
        step();
        cmd(1'b1, 1'b1, 1'b0);
        chk("t4_rec_wins", 32'(state_o), 1);
        chk("t4_no_load", 32'(load_req), 0);
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back('{pad: 1'b0, d: 16'(16'hA1 + i)});
            tick(16'(16'hA1 + i), 2);
        end
        push_pads(253);
        mic_sample = 16'hBEEF;
        sample_tick = 1'b1;
        stop = 1'b1;
        step();
        sample_tick = 1'b0;
        stop = 1'b0;
        mic_sample = '0;
        chk("t4_pad", 32'(state_o), 2);
        wait_state(3'd3, 2000, "t4_drain");
        chk("t4_rec_len", 32'(rec_len), 256);
        wait_state(3'd0, DRAIN + 50, "t4_idle");
        chk("t4_all_wr", wr_q.size(), 0);

        // 5: stop one cycle after an rd; the capture still completes
        step();
        rd_count = 0;
        snap = pv_count;
        cmd(1'b0, 1'b1, 1'b0);
        chk("t5_play", 32'(state_o), 4);
        pv_q.push_back(16'd1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("t5_rd", 32'(rd), 1);
        step();
        cmd(1'b0, 1'b0, 1'b1);
        chk("t5_idle", 32'(state_o), 0);
        chk("t5_load_drop", 32'(load_req), 0);
        repeat (6) step();
        chk("t5_one_capture", pv_count - snap, 1);
        chk("t5_all_pv", pv_q.size(), 0);

        // 6: reset mid-PAD, then play with empty take is ignored
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wr_q.push_back('{pad: 1'b0, d: 16'(16'h55 + i)});
            tick(16'(16'h55 + i), 2);
        end
        push_pads(254);
        cmd(1'b0, 1'b0, 1'b1);
        repeat (15) step();
        chk("t6_in_pad", 32'(state_o), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_state", 32'(state_o), 0);
        chk("t6_outs", 32'({wr, rd, play_valid, busy, store_req, load_req}), 0);
        chk("t6_rec_len", 32'(rec_len), 0);
        chk("t6_data", 32'({din, play_sample}), 0);
        wr_q.delete();
        cmd(1'b0, 1'b1, 1'b0);
        chk("t6_play_ignored", 32'(state_o), 0);
        repeat (3) step();
        chk("t6_no_load", 32'({load_req, busy, rd}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
